// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NREQ byte requesters share one UART
//   transmitter. A winner is picked in IDLE, granted for one cycle in START,
//   and owns the transmitter through WAIT until TxDone arrives.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//   When defined, a 16-bit watchdog aborts a WAIT that lasts TIMEOUT cycles
//   without TxDone. It pulses tx_err and bumps the saturating err_cnt.
//   When undefined, WAIT ends only on TxDone, tx_err is 0 and err_cnt is 8'h00.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-high reset
//   req       in   per-requester level request, held until granted
//   req_data  in   requester i byte on bits [8i+7:8i]
//   gnt       out  one-cycle grant pulse, one-hot
//   start_tx  out  one-cycle start pulse to the transmitter
//   TxData    out  byte presented to the transmitter, held until completion
//   TxDone    in   one-cycle completion pulse from the transmitter
//   busy      out  high from grant until the transfer ends
//   cur_id    out  index of the current owner
//   tx_err    out  one-cycle watchdog timeout pulse
//   err_cnt   out  saturating timeout count

module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*8-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                start_tx,
  output logic [7:0]          TxData,
  input  logic                TxDone,
  output logic                busy,
  output logic [IDW-1:0]      cur_id,
  output logic                tx_err,
  output logic [7:0]          err_cnt
);

  // The byte-lane select below assumes 4 requesters with a 2-bit index.
  if (NREQ != 4 || IDW != 2 || TIMEOUT < 16'd2) begin : g_bad_params
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_winner;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic [7:0]     winner_data;

  // Round-robin search: start one past the last owner and wrap.
  always_comb begin
    winner = last_winner;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDW'((32'(last_winner) + off) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign winner_data = req_data[{winner, 3'b000} +: 8];

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] wd;
`else
  assign tx_err  = 1'b0;
  assign err_cnt = 8'h00;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      gnt         <= '0;
      start_tx    <= 1'b0;
      busy        <= 1'b0;
      TxData      <= '0;
      cur_id      <= '0;
      last_winner <= IDW'(NREQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd          <= '0;
      tx_err      <= 1'b0;
      err_cnt     <= '0;
`endif
    end else begin
      gnt      <= '0;
      start_tx <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tx_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= START;
            gnt[winner] <= 1'b1;
            start_tx    <= 1'b1;
            busy        <= 1'b1;
            TxData      <= winner_data;
            cur_id      <= winner;
          end
        end
        START: begin
          // TxDone is deliberately not looked at here.
          state <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (TxDone) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last_winner <= cur_id;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (wd == TIMEOUT - 16'd1) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last_winner <= cur_id;
            tx_err      <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
